// File: rtl/ps2_key_rx.sv
// rtl/ps2_key_rx.sv - PS/2 keyboard receiver: sync, glitch filter, frame FSM, E0/F0 prefix decode, event FIFO
// Optional partial-frame timeout is built when PS2_KEY_RX_TIMEOUT_EN is defined.
module ps2_key_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_code,
  output logic                          ev_break,
  output logic                          ev_ext,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          frame_err,
  output logic                          timeout_err,
  output logic                          overflow
);

  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic             clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FLT_W-1:0] flt_cnt;
  logic             clk_f, clk_f_q;
  logic             strobe;

  state_t           state, state_nxt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             par_bit;
  logic             flag_ext, flag_brk;
  logic             frame_good;
  logic             timeout;

  logic             push_req;
  logic [10:0]      push_data;
  logic [10:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // The filtered level only follows after FILTER_LEN consecutive samples of the new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt_cnt <= '0;
      clk_f   <= 1'b1;
      clk_f_q <= 1'b1;
    end else begin
      clk_f_q <= clk_f;
      if (clk_s2 == clk_f) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
        clk_f   <= clk_s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + FLT_W'(1);
      end
    end
  end

  assign strobe = clk_f_q & ~clk_f;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = IDLE;
    end else if (strobe) begin
      case (state)
        IDLE:    if (!dat_s2) state_nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Odd parity over data plus parity bit, and the stop bit must be high.
  assign frame_good = dat_s2 & (^{shift, par_bit});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      shift     <= '0;
      par_bit   <= 1'b0;
      flag_ext  <= 1'b0;
      flag_brk  <= 1'b0;
      push_req  <= 1'b0;
      push_data <= '0;
      frame_err <= 1'b0;
    end else begin
      push_req  <= 1'b0;
      frame_err <= 1'b0;
      if (timeout) begin
        flag_ext <= 1'b0;
        flag_brk <= 1'b0;
      end else if (strobe) begin
        case (state)
          IDLE: bit_cnt <= '0;
          DATA: begin
            shift   <= {dat_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: par_bit <= dat_s2;
          STOP: begin
            if (!frame_good) begin
              frame_err <= 1'b1;
              flag_ext  <= 1'b0;
              flag_brk  <= 1'b0;
            end else if (shift == 8'hE0) begin
              flag_ext <= 1'b1;
            end else if (shift == 8'hF0) begin
              flag_brk <= 1'b1;
            end else begin
              push_req  <= 1'b1;
              push_data <= {flag_ext, flag_brk, shift};
              flag_ext  <= 1'b0;
              flag_brk  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PS2_KEY_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  // A strobe on the expiry cycle wins, so a late but valid bit is still taken.
  assign timeout = (state != IDLE) && !strobe && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout;
      if (state == IDLE || strobe || timeout) to_cnt <= '0;
      else                                    to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  assign timeout     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign full    = (ev_count == CNT_W'(FIFO_DEPTH));
  assign do_pop  = ev_valid & ev_ready;
  assign do_push = push_req & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ev_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   ev_count <= ev_count + CNT_W'(1);
        2'b01:   ev_count <= ev_count - CNT_W'(1);
        default: ;
      endcase
      if (push_req && full && !do_pop) overflow <= 1'b1;
    end
  end

  assign ev_valid = (ev_count != '0);
  assign {ev_ext, ev_break, ev_code} = ev_valid ? mem[rd_ptr] : 11'd0;

endmodule
